// File: rtl/dsi_pkg.sv
// Shared DSI lane definitions: clock-lane state encoding, default timing
// constants and output decode, reused by the clock- and data-lane controllers.
package dsi_pkg;

  typedef enum logic [3:0] {
    STOP,
    HS_RQST,
    BRIDGE,
    HS_ZERO,
    HS_PRE,
    ACTIVE,
    POST,
    TRAIL,
    EXIT
  } lane_state_e;

  localparam int unsigned T_LPX_DEF         = 4;
  localparam int unsigned T_CLK_PREPARE_DEF = 3;
  localparam int unsigned T_CLK_ZERO_DEF    = 16;
  localparam int unsigned T_CLK_PRE_DEF     = 2;
  localparam int unsigned T_CLK_POST_DEF    = 8;
  localparam int unsigned T_CLK_TRAIL_DEF   = 4;
  localparam int unsigned T_HS_EXIT_DEF     = 6;

  typedef struct packed {
    logic lp_p;
    logic lp_n;
    logic clk_hi_z;
    logic clk_enable;
    logic hs_ready;
  } lane_out_t;

  function automatic lane_out_t state_outputs(lane_state_e s);
    case (s)
      HS_RQST: return '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      BRIDGE:  return '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      HS_ZERO: return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      HS_PRE:  return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      ACTIVE:  return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      POST:    return '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      TRAIL:   return '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      default: return '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    endcase
  endfunction

  // A zero-length phase still occupies one cycle, so 0 loads like 1.
  function automatic logic [7:0] cnt_load(int unsigned t);
    return (t == 0) ? 8'd0 : 8'(t - 1);
  endfunction

endpackage

// File: rtl/clock_lane_ctrl.sv
// MIPI D-PHY clock-lane sequencer: walks LP-11 -> HS clocking -> LP-11 with
// all timed phases driven by one shared down-counter.
module clock_lane_ctrl
  import dsi_pkg::*;
#(
  parameter int unsigned T_LPX         = T_LPX_DEF,
  parameter int unsigned T_CLK_PREPARE = T_CLK_PREPARE_DEF,
  parameter int unsigned T_CLK_ZERO    = T_CLK_ZERO_DEF,
  parameter int unsigned T_CLK_PRE     = T_CLK_PRE_DEF,
  parameter int unsigned T_CLK_POST    = T_CLK_POST_DEF,
  parameter int unsigned T_CLK_TRAIL   = T_CLK_TRAIL_DEF,
  parameter int unsigned T_HS_EXIT     = T_HS_EXIT_DEF
) (
  input  logic byte_clk,
  input  logic byte_rst_n,
  input  logic hs_req,
  output logic hs_ready,
  output logic busy,
  output logic lp_p,
  output logic lp_n,
  output logic clk_enable,
  output logic clk_hi_z
);

  if (T_LPX > 255 || T_CLK_PREPARE > 255 || T_CLK_ZERO > 255 || T_CLK_PRE > 255 ||
      T_CLK_POST > 255 || T_CLK_TRAIL > 255 || T_HS_EXIT > 255) begin : g_bad_timing
    $error("clock_lane_ctrl: timing parameter exceeds 8-bit counter range");
  end

  lane_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  lane_out_t   out_q, out_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STOP: begin
        if (hs_req) begin
          state_d = HS_RQST;
          cnt_d   = cnt_load(T_LPX);
        end
      end
      ACTIVE: begin
        if (!hs_req) begin
          state_d = POST;
          cnt_d   = cnt_load(T_CLK_POST);
        end
      end
      default: begin
        // Timed phases ignore hs_req entirely; only the counter moves them on.
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          case (state_q)
            HS_RQST: begin state_d = BRIDGE;  cnt_d = cnt_load(T_CLK_PREPARE); end
            BRIDGE:  begin state_d = HS_ZERO; cnt_d = cnt_load(T_CLK_ZERO);    end
            HS_ZERO: begin state_d = HS_PRE;  cnt_d = cnt_load(T_CLK_PRE);     end
            HS_PRE:  begin state_d = ACTIVE;  cnt_d = 8'd0;                    end
            POST:    begin state_d = TRAIL;   cnt_d = cnt_load(T_CLK_TRAIL);   end
            TRAIL:   begin state_d = EXIT;    cnt_d = cnt_load(T_HS_EXIT);     end
            EXIT:    begin state_d = STOP;    cnt_d = 8'd0;                    end
            default: begin state_d = STOP;    cnt_d = 8'd0;                    end
          endcase
        end
      end
    endcase
    out_d  = state_outputs(state_d);
    busy_d = (state_d != STOP);
  end

  // Outputs are decoded from the next state so they flip on the same edge as state_q.
  always_ff @(posedge byte_clk or negedge byte_rst_n) begin
    if (!byte_rst_n) begin
      state_q <= STOP;
      cnt_q   <= 8'd0;
      out_q   <= state_outputs(STOP);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign lp_p       = out_q.lp_p;
  assign lp_n       = out_q.lp_n;
  assign clk_hi_z   = out_q.clk_hi_z;
  assign clk_enable = out_q.clk_enable;
  assign hs_ready   = out_q.hs_ready;
  assign busy       = busy_q;

endmodule

// File: tb/tb_clock_lane_ctrl.sv
// Directed bench for clock_lane_ctrl: startup/shutdown phase lengths, short
// pulses, re-request during shutdown, async reset and a zero-length HS_ZERO.
module tb_clock_lane_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic hs_req = 1'b0;
  logic hs_req2 = 1'b0;

  logic rdy1, busy1, lpp1, lpn1, en1, hz1;
  logic rdy2, busy2, lpp2, lpn2, en2, hz2;

  int checks = 0;
  int failures = 0;

  // Expected vectors {lp_p, lp_n, clk_hi_z, clk_enable, hs_ready, busy}
  localparam logic [5:0] E_STOP   = 6'b111000;
  localparam logic [5:0] E_RQST   = 6'b011001;
  localparam logic [5:0] E_BRIDGE = 6'b001001;
  localparam logic [5:0] E_ZERO   = 6'b000001;
  localparam logic [5:0] E_PRE    = 6'b000101;
  localparam logic [5:0] E_ACTIVE = 6'b000111;
  localparam logic [5:0] E_POST   = 6'b000101;
  localparam logic [5:0] E_TRAIL  = 6'b000001;
  localparam logic [5:0] E_EXIT   = 6'b111001;

  always #5 clk = ~clk;

  clock_lane_ctrl dut (
    .byte_clk(clk), .byte_rst_n(rst_n), .hs_req(hs_req),
    .hs_ready(rdy1), .busy(busy1), .lp_p(lpp1), .lp_n(lpn1),
    .clk_enable(en1), .clk_hi_z(hz1)
  );

  clock_lane_ctrl #(.T_CLK_ZERO(0)) dut_z0 (
    .byte_clk(clk), .byte_rst_n(rst_n), .hs_req(hs_req2),
    .hs_ready(rdy2), .busy(busy2), .lp_p(lpp2), .lp_n(lpn2),
    .clk_enable(en2), .clk_hi_z(hz2)
  );

  wire [5:0] obs1 = {lpp1, lpn1, hz1, en1, rdy1, busy1};
  wire [5:0] obs2 = {lpp2, lpn2, hz2, en2, rdy2, busy2};

  task automatic chk(input string tag, input logic [5:0] exp, input bit sel);
    logic [5:0] got;
    got = sel ? obs2 : obs1;
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_phase(input string tag, input logic [5:0] exp, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), exp, sel);
    end
  endtask

  task automatic startup_tail(input string p);
    run_phase({p, "_bridge"}, E_BRIDGE, 3, 1'b0);
    run_phase({p, "_zero"}, E_ZERO, 16, 1'b0);
    run_phase({p, "_pre"}, E_PRE, 2, 1'b0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk("reset_async", E_STOP, 1'b0);
    chk("reset_async_z0", E_STOP, 1'b1);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    run_phase("idle", E_STOP, 3, 1'b0);

    // Full startup then hold ACTIVE
    hs_req = 1'b1;
    run_phase("up_rqst", E_RQST, 4, 1'b0);
    startup_tail("up");
    run_phase("up_active", E_ACTIVE, 5, 1'b0);

    // Shutdown
    hs_req = 1'b0;
    run_phase("dn_post", E_POST, 8, 1'b0);
    run_phase("dn_trail", E_TRAIL, 4, 1'b0);
    run_phase("dn_exit", E_EXIT, 6, 1'b0);
    run_phase("dn_stop", E_STOP, 3, 1'b0);

    // Single-cycle request pulse
    hs_req = 1'b1;
    tick();
    chk("pulse_rqst0", E_RQST, 1'b0);
    hs_req = 1'b0;
    run_phase("pulse_rqst", E_RQST, 3, 1'b0);
    startup_tail("pulse");
    run_phase("pulse_active", E_ACTIVE, 1, 1'b0);
    run_phase("pulse_post", E_POST, 8, 1'b0);
    run_phase("pulse_trail", E_TRAIL, 4, 1'b0);
    run_phase("pulse_exit", E_EXIT, 6, 1'b0);
    run_phase("pulse_stop", E_STOP, 2, 1'b0);

    // Re-request during TRAIL does not cut shutdown short
    hs_req = 1'b1;
    run_phase("rr_rqst", E_RQST, 4, 1'b0);
    startup_tail("rr");
    run_phase("rr_active", E_ACTIVE, 2, 1'b0);
    hs_req = 1'b0;
    run_phase("rr_post", E_POST, 8, 1'b0);
    run_phase("rr_trail_a", E_TRAIL, 2, 1'b0);
    hs_req = 1'b1;
    run_phase("rr_trail_b", E_TRAIL, 2, 1'b0);
    run_phase("rr_exit", E_EXIT, 6, 1'b0);
    run_phase("rr_stop", E_STOP, 1, 1'b0);
    run_phase("rr_restart", E_RQST, 4, 1'b0);
    startup_tail("rr2");
    run_phase("rr2_active", E_ACTIVE, 2, 1'b0);

    // Asynchronous reset in the middle of ACTIVE
    #3 rst_n = 1'b0;
    #1 chk("rst_mid_active", E_STOP, 1'b0);
    #2 rst_n = 1'b1;
    run_phase("post_rst_rqst", E_RQST, 1, 1'b0);
    hs_req = 1'b0;
    run_phase("post_rst_rqst_b", E_RQST, 3, 1'b0);
    chk("z0_idle", E_STOP, 1'b1);

    // T_CLK_ZERO = 0 instance: HS_ZERO lasts one cycle
    hs_req2 = 1'b1;
    run_phase("z0_rqst", E_RQST, 4, 1'b1);
    run_phase("z0_bridge", E_BRIDGE, 3, 1'b1);
    run_phase("z0_zero", E_ZERO, 1, 1'b1);
    run_phase("z0_pre", E_PRE, 2, 1'b1);
    run_phase("z0_active", E_ACTIVE, 1, 1'b1);
    hs_req2 = 1'b0;
    run_phase("z0_post", E_POST, 1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
